// File: rtl/hawk_multi_seek_if.sv
// Host disk-controller bus bundle for the multi-drive seek controller.
// The host side drives requests; the controller returns ack, status and head positions.
interface hawk_multi_seek_if #(
  parameter int NUM_DRIVES = 4,
  parameter int CYL_BITS   = 9
);
  // One spare select code so that out-of-range drive numbers can be presented and ignored.
  localparam int SEL_W = $clog2(NUM_DRIVES + 1);

  logic                           en;
  logic                           cyl_strobe;
  logic                           rtzs;
  logic [SEL_W-1:0]               drive_sel;
  logic [CYL_BITS-1:0]            cyl_addr_in;
  logic                           addr_ack;
  logic [NUM_DRIVES-1:0]          invalid_addr;
  logic [NUM_DRIVES-1:0]          seek_error;
  logic [NUM_DRIVES-1:0]          seek_strobe;
  logic [NUM_DRIVES-1:0]          on_cyl;
  logic [NUM_DRIVES*CYL_BITS-1:0] cur_cyl;

  modport master (
    output en, cyl_strobe, rtzs, drive_sel, cyl_addr_in,
    input  addr_ack, invalid_addr, seek_error, seek_strobe, on_cyl, cur_cyl
  );

  modport slave (
    input  en, cyl_strobe, rtzs, drive_sel, cyl_addr_in,
    output addr_ack, invalid_addr, seek_error, seek_strobe, on_cyl, cur_cyl
  );
endinterface

// File: rtl/hawk_multi_seek_ctrl.sv
// Multi-drive seek controller: synchronises host seek/RTZ strobes and models per-drive
// head travel (step time per cylinder plus settle), tracking cylinder and status.
module hawk_multi_seek_ctrl #(
  parameter int NUM_DRIVES         = 4,
  parameter int NUM_CYL            = 408,
  parameter int CYL_BITS           = 9,
  parameter int CYCLES_PER_CYL     = 2,
  parameter int SETTLE_CYCLES      = 25,
  parameter int ACK_CYCLES         = 2,
  parameter bit INVALID_IS_ERROR   = 1'b1,
  parameter bit ERROR_DROPS_ON_CYL = 1'b1
) (
  input logic              clk,
  input logic              rst,
  hawk_multi_seek_if.slave bus
);
  localparam int SEL_W   = $clog2(NUM_DRIVES + 1);
  localparam int TMR_MAX = (CYCLES_PER_CYL > SETTLE_CYCLES) ? CYCLES_PER_CYL : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int ACK_W   = $clog2(ACK_CYCLES + 1);
  localparam logic [TMR_W-1:0] STEP_LAST   = TMR_W'(CYCLES_PER_CYL - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [ACK_W-1:0] ACK_LAST    = ACK_W'(ACK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEEK, SETTLE} state_t;

  logic                  strobe_p0, strobe_p1, strobe_p2;
  logic                  rtz_p0, rtz_p1, rtz_p2;
  state_t                state [NUM_DRIVES];
  logic [CYL_BITS-1:0]   cur   [NUM_DRIVES];
  logic [CYL_BITS-1:0]   tgt   [NUM_DRIVES];
  logic [TMR_W-1:0]      tmr   [NUM_DRIVES];
  logic [ACK_W-1:0]      ack_left;
  logic                  addr_ack;
  logic [NUM_DRIVES-1:0] invalid_addr, seek_error, seek_strobe, on_cyl;

  logic                  seek_edge, rtz_edge, req_vld, req_bad;
  logic [CYL_BITS-1:0]   req_cyl;
  logic [NUM_DRIVES-1:0] hit;

  function automatic logic [CYL_BITS-1:0] step_toward(input logic [CYL_BITS-1:0] from,
                                                      input logic [CYL_BITS-1:0] to);
    return (to > from) ? from + 1'b1 : from - 1'b1;
  endfunction

  // Detect stage: edges from the synchronised strobes; RTZ overrides a coincident seek.
  always_comb begin
    seek_edge = strobe_p1 & ~strobe_p2;
    rtz_edge  = ~rtz_p1 & rtz_p2;
    req_vld   = bus.en & (seek_edge | rtz_edge) & (bus.drive_sel < SEL_W'(NUM_DRIVES));
    req_cyl   = rtz_edge ? '0 : bus.cyl_addr_in;
    req_bad   = !rtz_edge && ({1'b0, bus.cyl_addr_in} >= (CYL_BITS + 1)'(NUM_CYL));
    hit       = '0;
    for (int d = 0; d < NUM_DRIVES; d++)
      hit[d] = req_vld && (bus.drive_sel == SEL_W'(d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_p0    <= 1'b0;
      strobe_p1    <= 1'b0;
      strobe_p2    <= 1'b0;
      rtz_p0       <= 1'b0;
      rtz_p1       <= 1'b0;
      rtz_p2       <= 1'b0;
      ack_left     <= '0;
      addr_ack     <= 1'b0;
      invalid_addr <= '0;
      seek_error   <= '0;
      seek_strobe  <= '0;
      on_cyl       <= '1;
      for (int d = 0; d < NUM_DRIVES; d++) begin
        state[d] <= IDLE;
        cur[d]   <= '0;
        tgt[d]   <= '0;
        tmr[d]   <= '0;
      end
    end else begin
      strobe_p0   <= bus.cyl_strobe;
      strobe_p1   <= strobe_p0;
      strobe_p2   <= strobe_p1;
      rtz_p0      <= bus.rtzs;
      rtz_p1      <= rtz_p0;
      rtz_p2      <= rtz_p1;
      seek_strobe <= '0;

      if (req_vld && !req_bad) begin
        addr_ack <= 1'b1;
        ack_left <= ACK_LAST;
      end else if (ack_left != '0) begin
        ack_left <= ack_left - 1'b1;
      end else begin
        addr_ack <= 1'b0;
      end

      // Drive stage: accepted requests restart travel from the present cylinder.
      for (int d = 0; d < NUM_DRIVES; d++) begin
        if (hit[d] && !req_bad) begin
          tgt[d]          <= req_cyl;
          tmr[d]          <= '0;
          state[d]        <= (req_cyl == cur[d]) ? SETTLE : SEEK;
          seek_strobe[d]  <= 1'b1;
          on_cyl[d]       <= 1'b0;
          seek_error[d]   <= 1'b0;
          invalid_addr[d] <= 1'b0;
        end else begin
          case (state[d])
            SEEK: begin
              if (tmr[d] == STEP_LAST) begin
                tmr[d] <= '0;
                cur[d] <= step_toward(cur[d], tgt[d]);
                if (step_toward(cur[d], tgt[d]) == tgt[d]) state[d] <= SETTLE;
              end else begin
                tmr[d] <= tmr[d] + 1'b1;
              end
            end
            SETTLE: begin
              if (tmr[d] == SETTLE_LAST) begin
                tmr[d]    <= '0;
                state[d]  <= IDLE;
                on_cyl[d] <= !(ERROR_DROPS_ON_CYL && seek_error[d]);
              end else begin
                tmr[d] <= tmr[d] + 1'b1;
              end
            end
            default: ;
          endcase
          // An out-of-range request leaves motion alone and only flags status.
          if (hit[d]) begin
            invalid_addr[d] <= 1'b1;
            seek_error[d]   <= INVALID_IS_ERROR;
            if (ERROR_DROPS_ON_CYL && INVALID_IS_ERROR) on_cyl[d] <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.addr_ack     = addr_ack;
  assign bus.invalid_addr = invalid_addr;
  assign bus.seek_error   = seek_error;
  assign bus.seek_strobe  = seek_strobe;
  assign bus.on_cyl       = on_cyl;

  for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_cur
    assign bus.cur_cyl[g*CYL_BITS +: CYL_BITS] = cur[g];
  end
endmodule
